game_ctrl: RTL
==============

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 9: points needed to win a game.
REQ-002 Parameter SERVE_TICKS, default 2000: cycles the ball is held at centre before each serve (1 s at 2 kHz).
REQ-003 Parameter SPEEDUP_TICKS, default 4000: PLAY cycles between speed increments.
REQ-004 Parameter SPEED_INIT, default 4: speed applied at every serve.
REQ-005 clk  in  1  game tick clock, 2 kHz nominal.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  start button, synchronous level; only its rising edge is used.
REQ-008 out_left  in  1  ball crossed the far-left edge; single-cycle pulse.
REQ-009 out_right  in  1  ball crossed the far-right edge; single-cycle pulse.
REQ-010 ball_reset  out  1  holds the ball at centre; direction is drawn from entropy.
REQ-011 entropy  out  5  pseudo-random direction seed.
REQ-012 speed  out  4  ball speed, 0-15.
REQ-013 score_l  out  4  left player score.
REQ-014 score_r  out  4  right player score.
REQ-015 playing  out  1  high in PLAY only.
REQ-016 game_over  out  1  high in OVER only.
REQ-017 winner  out  1  valid in OVER: 0 = left won, 1 = right won.

Function
REQ-018 The FSM SHALL have four states: IDLE, SERVE, PLAY, OVER; all outputs are registered.
REQ-019 Start edge: start_q <= start; start_rise = start & ~start_q.
REQ-020 IDLE: ball_reset=1; on start_rise -> clear both scores, set speed=SPEED_INIT, clear the serve counter, go to SERVE.
REQ-021 SERVE: ball_reset=1; the serve counter increments each cycle; when it reaches SERVE_TICKS-1 -> PLAY. ball_reset SHALL drop in the same edge, so ball_reset is high for exactly SERVE_TICKS cycles.
REQ-022 PLAY: ball_reset=0; the speedup counter increments each cycle; at SPEEDUP_TICKS-1 the counter clears and speed increments, saturating at 15.
REQ-023 PLAY, out_left=1 only -> score_r+1; out_right=1 only -> score_l+1.
REQ-024 PLAY, out_left and out_right in the same cycle -> no score change; re-serve per REQ-025.
REQ-025 After any out event, if neither updated score equals WIN_SCORE -> SERVE with the serve counter cleared, speed=SPEED_INIT and the speedup counter cleared.
REQ-026 If an updated score equals WIN_SCORE -> OVER with winner registered in the same edge.
REQ-027 OVER: ball_reset=1, speed held, scores frozen; on start_rise -> same action as IDLE+start (REQ-020).
REQ-028 out_left/out_right SHALL be ignored in IDLE, SERVE and OVER; start SHALL be ignored in SERVE and PLAY.
REQ-029 Entropy: a 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1, advances every cycle in every state; entropy = lfsr[4:0].
REQ-030 Scores SHALL never exceed WIN_SCORE; WIN_SCORE SHALL be in 1..15 and SERVE_TICKS, SPEEDUP_TICKS SHALL be >= 2 (elaboration check).

Reset
REQ-031 reset SHALL asynchronously force: state=IDLE, ball_reset=1, speed=SPEED_INIT, score_l=score_r=0, playing=0, game_over=0, winner=0, lfsr=16'hACE1, start_q=1 (a held button does not start a game), and all counters=0.
REQ-032 reset mid-PLAY or mid-SERVE SHALL discard all progress; the first state after release is IDLE.

Structure
REQ-033 The state encoding (IDLE=0, SERVE=1, PLAY=2, OVER=3) and the LFSR seed/taps SHALL live in the shared package pong_pkg.
REQ-034 The LFSR SHALL be the sub-module lfsr16 (clk, reset, q[15:0]), reusable by other blocks.

Verification
REQ-035 Reset, then start pulse -> ball_reset high for exactly 2000 cycles, then playing=1, speed=4, scores 0/0.
REQ-036 PLAY held 8000 cycles without out events -> speed 4->5 at cycle 4000 and ->6 at cycle 8000; with SPEEDUP_TICKS=2, speed saturates at 15 and stays there.
REQ-037 out_left pulse in PLAY -> score_r=1, score_l=0, next cycle ball_reset=1, speed=4, SERVE again; out_right -> score_l increments.
REQ-038 Simultaneous out_left+out_right in PLAY -> scores unchanged, re-serve; out pulses during SERVE/OVER -> scores unchanged.
REQ-039 WIN_SCORE=2: two out_right events -> game_over=1, winner=0, score_l=2; start held high through OVER without an edge -> stays OVER; a fresh start edge -> scores 0/0, SERVE.
REQ-040 reset asserted mid-PLAY at score 3/1 -> asynchronous return to IDLE, scores 0/0, entropy sequence restarts from 16'hACE1 (first entropy=5'h01).

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the pong game blocks: FSM state encoding and the
// entropy LFSR seed/taps with its next-state helper.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    logic [15:0] shifted;
    shifted = cur >> 1;
    return cur[0] ? (shifted ^ LFSR_TAPS) : shifted;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; restarts from the shared seed on reset.
module lfsr16
  import pong_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  // Advance one step every clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= LFSR_SEED;
    end else begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Pong game controller: serve timing, scoring, speed ramp and win detection.
// All outputs are registered; entropy comes straight from the LFSR register.
module game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE     = 9,
  parameter int SERVE_TICKS   = 2000,
  parameter int SPEEDUP_TICKS = 4000,
  parameter int SPEED_INIT    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       out_left,
  input  logic       out_right,
  output logic       ball_reset,
  output logic [4:0] entropy,
  output logic [3:0] speed,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       playing,
  output logic       game_over,
  output logic       winner
);

  if (WIN_SCORE < 1 || WIN_SCORE > 15 || SERVE_TICKS < 2 || SPEEDUP_TICKS < 2) begin : g_param_err
    $error("game_ctrl: WIN_SCORE must be 1..15, SERVE_TICKS and SPEEDUP_TICKS >= 2");
  end

  localparam int SW = $clog2(SERVE_TICKS);
  localparam int UW = $clog2(SPEEDUP_TICKS);
  localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_TICKS - 1);
  localparam logic [UW-1:0] SPD_LAST   = UW'(SPEEDUP_TICKS - 1);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);
  localparam logic [3:0]    SPD0       = 4'(SPEED_INIT);

  state_t        state;
  state_t        state_nxt;
  logic          start_q;
  logic [SW-1:0] serve_cnt;
  logic [UW-1:0] spd_cnt;
  logic [15:0]   lfsr;
  logic          lfsr_unused;
  logic          ball_reset_nxt;
  logic          playing_nxt;
  logic          game_over_nxt;

  logic       start_rise;
  logic       out_hit;
  logic       serve_done;
  logic       left_only;
  logic       right_only;
  logic [3:0] score_l_upd;
  logic [3:0] score_r_upd;
  logic       won_left;
  logic       won_right;
  logic       game_won;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  assign entropy     = lfsr[4:0];
  assign lfsr_unused = ^lfsr[15:5];

  assign start_rise  = start & ~start_q;
  assign out_hit     = out_left | out_right;
  assign serve_done  = (serve_cnt == SERVE_LAST);
  // A ball leaving on the left scores for the right player and vice versa
  assign left_only   = out_left & ~out_right;
  assign right_only  = out_right & ~out_left;
  assign score_l_upd = score_l + {3'b000, right_only};
  assign score_r_upd = score_r + {3'b000, left_only};
  assign won_left    = (score_l_upd == WIN);
  assign won_right   = (score_r_upd == WIN);
  assign game_won    = won_left | won_right;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      start_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      start_q <= start;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_rise) state_nxt = ST_SERVE;
        else            state_nxt = ST_IDLE;
      end
      ST_SERVE: begin
        if (serve_done) state_nxt = ST_PLAY;
        else            state_nxt = ST_SERVE;
      end
      ST_PLAY: begin
        if (out_hit && game_won) state_nxt = ST_OVER;
        else if (out_hit)        state_nxt = ST_SERVE;
        else                     state_nxt = ST_PLAY;
      end
      ST_OVER: begin
        if (start_rise) state_nxt = ST_SERVE;
        else            state_nxt = ST_OVER;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status flags follow the state being entered so they change on the same edge
  always_comb begin
    ball_reset_nxt = 1'b1;
    playing_nxt    = 1'b0;
    game_over_nxt  = 1'b0;
    case (state_nxt)
      ST_PLAY: begin
        ball_reset_nxt = 1'b0;
        playing_nxt    = 1'b1;
      end
      ST_OVER: game_over_nxt = 1'b1;
      default: ball_reset_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ball_reset <= 1'b1;
      playing    <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      ball_reset <= ball_reset_nxt;
      playing    <= playing_nxt;
      game_over  <= game_over_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      speed     <= SPD0;
      winner    <= 1'b0;
      serve_cnt <= '0;
      spd_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start_rise) begin
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            speed     <= SPD0;
            serve_cnt <= '0;
            spd_cnt   <= '0;
          end
        end
        ST_SERVE: begin
          spd_cnt   <= '0;
          serve_cnt <= serve_done ? '0 : serve_cnt + SW'(1);
        end
        ST_PLAY: begin
          // A point ends the rally; speed is kept only when the game is decided
          if (out_hit) begin
            score_l <= score_l_upd;
            score_r <= score_r_upd;
            if (game_won) begin
              winner <= won_right;
            end else begin
              speed     <= SPD0;
              serve_cnt <= '0;
              spd_cnt   <= '0;
            end
          end else if (spd_cnt == SPD_LAST) begin
            spd_cnt <= '0;
            if (speed != 4'd15) speed <= speed + 4'd1;
          end else begin
            spd_cnt <= spd_cnt + UW'(1);
          end
        end
        default: begin
          serve_cnt <= '0;
          spd_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
